// File: rtl/nv_ram_rwsp_fifo_ctrl.sv
// FIFO controller sequencing a registered-output 1R/1W RAM macro as a circular buffer.
// Two-stage RAM read (address capture, then output register) exposed as a valid/ready pop port.
module nv_ram_rwsp_fifo_ctrl #(
    parameter int unsigned DEPTH = 245,
    parameter int unsigned AW    = 8,
    parameter int unsigned DW    = 514
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_pvld,
    output logic          wr_prdy,
    input  logic [DW-1:0] wr_pd,
    output logic          rd_pvld,
    input  logic          rd_prdy,
    output logic [DW-1:0] rd_pd,
    output logic [AW:0]   count,
    output logic          idle,
    output logic          ram_we,
    output logic [AW-1:0] ram_wa,
    output logic [DW-1:0] ram_di,
    output logic          ram_re,
    output logic [AW-1:0] ram_ra,
    output logic          ram_ore,
    input  logic [DW-1:0] ram_dout,
    input  logic [31:0]   pwrbus_ram_pd,
    output logic [31:0]   ram_pwrbus_pd
);

    localparam logic [AW:0]   DepthC = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LastC  = AW'(DEPTH - 1);

    logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [AW:0]   uf_q, uf_d, count_q, count_d;
    logic          s1_vld_q, s1_vld_d, s2_vld_q, s2_vld_d;
    logic          push, pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == LastC) ? '0 : p + AW'(1);
    endfunction

    always_comb begin
        wr_prdy  = (count_q < DepthC);
        // No write strobe may reach the RAM while reset is held.
        push     = wr_pvld && wr_prdy && !rst;
        pop      = s2_vld_q && rd_prdy;
        ram_ore  = s1_vld_q && (!s2_vld_q || rd_prdy);
        ram_re   = (uf_q != '0) && (!s1_vld_q || ram_ore);

        wp_d     = push ? ptr_inc(wp_q) : wp_q;
        rp_d     = ram_re ? ptr_inc(rp_q) : rp_q;

        uf_d     = uf_q;
        if (push && !ram_re) begin
            uf_d = uf_q + (AW+1)'(1);
        end else if (!push && ram_re) begin
            uf_d = uf_q - (AW+1)'(1);
        end

        // Occupancy covers entries still in the read pipeline; slots free only at pop.
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + (AW+1)'(1);
        end else if (!push && pop) begin
            count_d = count_q - (AW+1)'(1);
        end

        s1_vld_d = ram_re ? 1'b1 : (ram_ore ? 1'b0 : s1_vld_q);
        s2_vld_d = ram_ore ? 1'b1 : (pop ? 1'b0 : s2_vld_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp_q     <= '0;
            rp_q     <= '0;
            uf_q     <= '0;
            count_q  <= '0;
            s1_vld_q <= 1'b0;
            s2_vld_q <= 1'b0;
        end else begin
            wp_q     <= wp_d;
            rp_q     <= rp_d;
            uf_q     <= uf_d;
            count_q  <= count_d;
            s1_vld_q <= s1_vld_d;
            s2_vld_q <= s2_vld_d;
        end
    end

    assign ram_we        = push;
    assign ram_wa        = wp_q;
    assign ram_di        = wr_pd;
    assign ram_ra        = rp_q;
    assign rd_pvld       = s2_vld_q;
    assign rd_pd         = ram_dout;
    assign count         = count_q;
    assign idle          = (count_q == '0);
    assign ram_pwrbus_pd = pwrbus_ram_pd;

endmodule

// File: tb/tb_nv_ram_rwsp_fifo_ctrl.sv
// Bench for nv_ram_rwsp_fifo_ctrl: behavioural two-stage RAM, directed vector table,
// and scoreboarded sequences for full/stall/wrap/reset corners.
module tb_nv_ram_rwsp_fifo_ctrl;

    localparam int unsigned DEPTH = 245;
    localparam int unsigned AW    = 8;
    localparam int unsigned DW    = 514;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_pvld = 1'b0;
    logic          wr_prdy;
    logic [DW-1:0] wr_pd = '0;
    logic          rd_pvld;
    logic          rd_prdy = 1'b0;
    logic [DW-1:0] rd_pd;
    logic [AW:0]   count;
    logic          idle;
    logic          ram_we;
    logic [AW-1:0] ram_wa;
    logic [DW-1:0] ram_di;
    logic          ram_re;
    logic [AW-1:0] ram_ra;
    logic          ram_ore;
    logic [DW-1:0] ram_dout = '0;
    logic [31:0]   pwrbus_ram_pd = 32'hA5A5_1234;
    logic [31:0]   ram_pwrbus_pd;

    always #5 clk = ~clk;

    nv_ram_rwsp_fifo_ctrl #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_pvld      (wr_pvld),
        .wr_prdy      (wr_prdy),
        .wr_pd        (wr_pd),
        .rd_pvld      (rd_pvld),
        .rd_prdy      (rd_prdy),
        .rd_pd        (rd_pd),
        .count        (count),
        .idle         (idle),
        .ram_we       (ram_we),
        .ram_wa       (ram_wa),
        .ram_di       (ram_di),
        .ram_re       (ram_re),
        .ram_ra       (ram_ra),
        .ram_ore      (ram_ore),
        .ram_dout     (ram_dout),
        .pwrbus_ram_pd(pwrbus_ram_pd),
        .ram_pwrbus_pd(ram_pwrbus_pd)
    );

    // Behavioural RAM macro: write port, address register, output register.
    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] ram_addr_q = '0;
    always @(posedge clk) begin
        if (ram_we) mem[ram_wa] <= ram_di;
        if (ram_re) ram_addr_q <= ram_ra;
        if (ram_ore) ram_dout <= mem[ram_addr_q];
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard state
    logic [DW-1:0] q[$];
    int unsigned   mwp = 0;
    int unsigned   mrp = 0;
    int            pushes = 0;

    function automatic int unsigned inc(input int unsigned p);
        return (p == DEPTH - 1) ? 0 : p + 1;
    endfunction

    task automatic cyc(input logic v, input logic [DW-1:0] d, input logic r);
        logic exp_push;
        @(negedge clk);
        wr_pvld = v;
        wr_pd   = d;
        rd_prdy = r;
        #1;
        exp_push = v && (q.size() < DEPTH);
        check("wr_prdy", DW'(wr_prdy), DW'(q.size() < DEPTH));
        check("count", DW'(count), DW'(q.size()));
        check("ram_we", DW'(ram_we), DW'(exp_push));
        if (exp_push) begin
            check("ram_wa", DW'(ram_wa), DW'(mwp));
            q.push_back(d);
            mwp = inc(mwp);
            pushes++;
        end
        if (ram_re) begin
            check("ram_ra", DW'(ram_ra), DW'(mrp));
            mrp = inc(mrp);
        end
        if (rd_pvld && r) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pop_empty: got pop expected no pop");
            end else begin
                check("rd_pd", rd_pd, q.pop_front());
            end
        end
    endtask

    typedef struct {
        logic        rst;
        logic        wv;
        logic [15:0] wd;
        logic        rr;
        logic        wr_prdy;
        logic        rd_pvld;
        logic        idle;
        logic        we;
        logic        re;
        logic        ore;
        logic [AW:0] cnt;
        logic        chk_pd;
        logic [15:0] pd;
    } vec_t;

    vec_t vecs [19];

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [DW-1:0] head;
        // rst wv wd rr | wr_prdy pvld idle we re ore cnt chk pd
        vecs[0]  = '{1, 1, 16'h0, 1, 1, 0, 1, 0, 0, 0, 0, 0, 16'h0};
        vecs[1]  = '{0, 1, 16'h1, 1, 1, 0, 1, 1, 0, 0, 0, 0, 16'h0};
        vecs[2]  = '{0, 0, 16'h0, 1, 1, 0, 0, 0, 1, 0, 1, 0, 16'h0};
        vecs[3]  = '{0, 0, 16'h0, 1, 1, 0, 0, 0, 0, 1, 1, 0, 16'h0};
        vecs[4]  = '{0, 0, 16'h0, 1, 1, 1, 0, 0, 0, 0, 1, 1, 16'h1};
        vecs[5]  = '{0, 0, 16'h0, 1, 1, 0, 1, 0, 0, 0, 0, 0, 16'h0};
        vecs[6]  = '{0, 1, 16'h2, 1, 1, 0, 1, 1, 0, 0, 0, 0, 16'h0};
        vecs[7]  = '{0, 1, 16'h3, 1, 1, 0, 0, 1, 1, 0, 1, 0, 16'h0};
        vecs[8]  = '{0, 0, 16'h0, 1, 1, 0, 0, 0, 1, 1, 2, 0, 16'h0};
        vecs[9]  = '{0, 0, 16'h0, 1, 1, 1, 0, 0, 0, 1, 2, 1, 16'h2};
        vecs[10] = '{0, 0, 16'h0, 1, 1, 1, 0, 0, 0, 0, 1, 1, 16'h3};
        vecs[11] = '{0, 0, 16'h0, 1, 1, 0, 1, 0, 0, 0, 0, 0, 16'h0};
        vecs[12] = '{0, 1, 16'h4, 0, 1, 0, 1, 1, 0, 0, 0, 0, 16'h0};
        vecs[13] = '{0, 0, 16'h0, 0, 1, 0, 0, 0, 1, 0, 1, 0, 16'h0};
        vecs[14] = '{0, 0, 16'h0, 0, 1, 0, 0, 0, 0, 1, 1, 0, 16'h0};
        vecs[15] = '{0, 0, 16'h0, 0, 1, 1, 0, 0, 0, 0, 1, 1, 16'h4};
        vecs[16] = '{0, 0, 16'h0, 0, 1, 1, 0, 0, 0, 0, 1, 1, 16'h4};
        vecs[17] = '{0, 0, 16'h0, 1, 1, 1, 0, 0, 0, 0, 1, 1, 16'h4};
        vecs[18] = '{0, 0, 16'h0, 1, 1, 0, 1, 0, 0, 0, 0, 0, 16'h0};

        #1;
        check("pwrbus", DW'(ram_pwrbus_pd), DW'(32'hA5A5_1234));

        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            rst     = vecs[i].rst;
            wr_pvld = vecs[i].wv;
            wr_pd   = DW'(vecs[i].wd);
            rd_prdy = vecs[i].rr;
            #1;
            check($sformatf("vec%0d{prdy,pvld,idle,we,re,ore,cnt}", i),
                  DW'({wr_prdy, rd_pvld, idle, ram_we, ram_re, ram_ore, count}),
                  DW'({vecs[i].wr_prdy, vecs[i].rd_pvld, vecs[i].idle, vecs[i].we,
                       vecs[i].re, vecs[i].ore, vecs[i].cnt}));
            if (vecs[i].chk_pd) check($sformatf("vec%0d_rd_pd", i), rd_pd, DW'(vecs[i].pd));
        end

        // Fresh start for scoreboarded sequences.
        @(negedge clk);
        rst = 1'b1;
        wr_pvld = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        q.delete();
        mwp = 0;
        mrp = 0;

        // Fill to full with the consumer stalled.
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, DW'(i + 32'h100), 1'b0);
        cyc(1'b0, '0, 1'b0);
        check("full_count", DW'(count), DW'(DEPTH));
        check("full_wr_prdy", DW'(wr_prdy), DW'(0));

        // Stall: output register and address register hold.
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, '0, 1'b0);
            head = q[0];
            check("stall_pvld", DW'(rd_pvld), DW'(1));
            check("stall_rd_pd", rd_pd, head);
            check("stall_ore", DW'(ram_ore), DW'(0));
            check("stall_re", DW'(ram_re), DW'(0));
        end

        // Full boundary: pop does not admit a same-cycle push.
        cyc(1'b1, DW'(32'h5555), 1'b1);
        check("full_same_cycle_we", DW'(ram_we), DW'(0));
        cyc(1'b1, DW'(32'h5555), 1'b0);
        check("full_next_cycle_we", DW'(ram_we), DW'(1));
        cyc(1'b0, '0, 1'b0);
        check("refull_count", DW'(count), DW'(DEPTH));

        // Drain back-to-back with no bubble.
        for (int i = 0; i < DEPTH; i++) begin
            cyc(1'b0, '0, 1'b1);
            check("drain_no_bubble", DW'(rd_pvld), DW'(1));
        end
        cyc(1'b0, '0, 1'b1);
        check("drained_idle", DW'(idle), DW'(1));

        // Random streaming; pointers wrap twice from the current position.
        pushes = 0;
        for (int c = 0; c < 6000 && pushes < 600; c++) begin
            cyc($urandom_range(0, 3) != 0, DW'({17{$urandom()}}), $urandom_range(0, 3) != 0);
        end
        check("stream_pushes", DW'(pushes >= 600), DW'(1));
        for (int c = 0; c < 20 && q.size() != 0; c++) cyc(1'b0, '0, 1'b1);
        check("stream_drained", DW'(q.size()), DW'(0));

        // Reset mid-stream with 37 entries held.
        for (int i = 0; i < 37; i++) cyc(1'b1, DW'(i + 32'h700), 1'b0);
        cyc(1'b0, '0, 1'b0);
        check("pre_reset_count", DW'(count), DW'(37));
        @(negedge clk);
        wr_pvld = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_pvld", DW'(rd_pvld), DW'(0));
        check("rst_count", DW'(count), DW'(0));
        check("rst_wr_prdy", DW'(wr_prdy), DW'(1));
        check("rst_idle", DW'(idle), DW'(1));
        check("rst_re_ore", DW'({ram_re, ram_ore}), DW'(0));
        @(negedge clk);
        rst = 1'b0;
        q.delete();
        mwp = 0;
        mrp = 0;
        cyc(1'b1, DW'(32'hA5), 1'b1);
        for (int c = 0; c < 10 && q.size() != 0; c++) cyc(1'b0, '0, 1'b1);
        check("post_reset_popped", DW'(q.size()), DW'(0));
        cyc(1'b0, '0, 1'b1);
        check("post_reset_idle", DW'(idle), DW'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
